// File: rtl/key_event_decoder.sv
// Turns a debounced key level into one-cycle press/release/long/repeat events,
// plus a held level and a wrapping press counter.
module key_event_decoder #(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned LONG_CYCLES   = 1000,
    parameter int unsigned REPEAT_CYCLES = 200,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keyin,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {StIdle, StPressed, StLong} state_e;

    localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic             KeyIdle    = ACTIVE_LOW;

    state_e           state_q;
    logic             key_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pressed;

    // The FSM only ever looks at the registered key sample.
    assign pressed = (key_q != KeyIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            key_q         <= KeyIdle;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            key_q         <= keyin;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pressed) begin
                        state_q     <= StPressed;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                        cnt_q       <= '0;
                        held        <= 1'b1;
                    end
                end
                StPressed: begin
                    // Release is tested first so it wins over a coincident long event.
                    if (!pressed) begin
                        state_q       <= StIdle;
                        release_pulse <= 1'b1;
                        cnt_q         <= '0;
                        held          <= 1'b0;
                    end else if (cnt_q == LongLast) begin
                        state_q    <= StLong;
                        long_pulse <= 1'b1;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StLong: begin
                    if (!pressed) begin
                        state_q       <= StIdle;
                        release_pulse <= 1'b1;
                        cnt_q         <= '0;
                        held          <= 1'b0;
                    end else if (REPEAT_EN && cnt_q == RepeatLast) begin
                        repeat_pulse <= 1'b1;
                        cnt_q        <= '0;
                    end else if (REPEAT_EN) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    held    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: expected events are queued with their cycle numbers
// as stimulus is driven, and checked off as the DUT emits pulses.
module tb_key_event_decoder;

    logic       clk;
    logic       rst;
    logic       keyin;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t   exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    npress = 0;
    int    nrelease = 0;
    string kind_name[4] = '{"press", "release", "long", "repeat"};

    key_event_decoder #(
        .ACTIVE_LOW   (1'b1),
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .REPEAT_EN    (1'b1),
        .CNT_W        (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .keyin        (keyin),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed pulse must match the head of the expected queue.
    always @(negedge clk) begin
        logic [3:0] p;
        ev_t        e;
        p = {repeat_pulse, long_pulse, release_pulse, press_pulse};
        if (p != 4'b0) begin
            total++;
            if ($countones(p) != 1) begin
                bad++;
                $display("FAIL pulse_exclusive cyc=%0d pulses=%b required exactly one", cyc, p);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (p[k]) begin
                total++;
                if (k == 0) npress++;
                if (k == 1) nrelease++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_%s cyc=%0d required no pulse", kind_name[k], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != k || e.cyc != cyc) begin
                        bad++;
                        $display("FAIL event got %s@%0d required %s@%0d",
                                 kind_name[k], cyc, kind_name[e.kind], e.cyc);
                    end
                end
            end
        end
    end

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int kind, input int at);
        exp_q.push_back('{kind: kind, cyc: at});
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        keyin = 1'b1;
        cycle(5);
        total++;
        if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got %b required 00000",
                     {press_pulse, release_pulse, long_pulse, repeat_pulse, held});
        end
        total++;
        if (press_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_count got %0d required 0", press_count);
        end
        rst = 1'b0;
        cycle(20);
        total++;
        if ({held, press_count} !== 9'b0) begin
            bad++;
            $display("FAIL idle_after_reset held=%b count=%0d required 0/0", held, press_count);
        end
    endtask

    task automatic test_short_press;
        int t;
        int nheld;
        t     = cyc;
        nheld = 0;
        push(0, t + 2);
        push(1, t + 7);
        keyin = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) keyin = 1'b1;
            cycle(1);
            if (held === 1'b1) nheld++;
        end
        total++;
        if (nheld != 5) begin
            bad++;
            $display("FAIL short_held_cycles got %0d required 5", nheld);
        end
        total++;
        if (press_count !== 8'd1) begin
            bad++;
            $display("FAIL short_count got %0d required 1", press_count);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL short_missing got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_long_hold;
        int t;
        t = cyc;
        push(0, t + 2);
        push(2, t + 10);
        for (int r = 14; r <= 30; r += 4) push(3, t + r);
        push(1, t + 32);
        keyin = 1'b0;
        cycle(30);
        total++;
        if (held !== 1'b1) begin
            bad++;
            $display("FAIL long_held got %b required 1", held);
        end
        keyin = 1'b1;
        cycle(6);
        total++;
        if (held !== 1'b0 || press_count !== 8'd2) begin
            bad++;
            $display("FAIL long_after held=%b count=%0d required 0/2", held, press_count);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL long_missing got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_release_at_terminal;
        int t;
        t = cyc;
        push(0, t + 2);
        push(1, t + 10);
        keyin = 1'b0;
        cycle(8);
        keyin = 1'b1;
        cycle(6);
        total++;
        if (held !== 1'b0 || press_count !== 8'd3) begin
            bad++;
            $display("FAIL terminal_after held=%b count=%0d required 0/3", held, press_count);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL terminal_missing got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        int t;
        t = cyc;
        push(0, t + 2);
        keyin = 1'b0;
        cycle(4);
        push(1, t + 6);
        keyin = 1'b1;
        cycle(1);
        push(0, t + 7);
        keyin = 1'b0;
        cycle(3);
        push(1, t + 10);
        keyin = 1'b1;
        cycle(6);
        total++;
        if (press_count !== 8'd5) begin
            bad++;
            $display("FAIL b2b_count got %0d required 5", press_count);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_missing got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_wrap;
        int t;
        rst   = 1'b1;
        keyin = 1'b1;
        cycle(2);
        rst = 1'b0;
        cycle(2);
        total++;
        if (press_count !== 8'd0) begin
            bad++;
            $display("FAIL wrap_start got %0d required 0", press_count);
        end
        npress   = 0;
        nrelease = 0;
        for (int i = 0; i < 257; i++) begin
            t = cyc;
            push(0, t + 2);
            push(1, t + 4);
            keyin = 1'b0;
            cycle(2);
            keyin = 1'b1;
            cycle(2);
            if (i == 255) begin
                total++;
                if (press_count !== 8'd0) begin
                    bad++;
                    $display("FAIL wrap_256 got %0d required 0", press_count);
                end
            end
        end
        cycle(4);
        total++;
        if (press_count !== 8'd1) begin
            bad++;
            $display("FAIL wrap_257 got %0d required 1", press_count);
        end
        total++;
        if (npress != 257 || nrelease != 257) begin
            bad++;
            $display("FAIL wrap_pulses got %0d/%0d required 257/257", npress, nrelease);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL wrap_missing got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_in_long;
        int t;
        t = cyc;
        push(0, t + 2);
        push(2, t + 10);
        push(3, t + 14);
        push(3, t + 18);
        keyin = 1'b0;
        cycle(19);
        rst = 1'b1;
        cycle(1);
        total++;
        if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held} !== 5'b0
            || press_count !== 8'd0) begin
            bad++;
            $display("FAIL rst_long_outputs got %b count=%0d required 00000 count=0",
                     {press_pulse, release_pulse, long_pulse, repeat_pulse, held}, press_count);
        end
        rst = 1'b0;
        push(0, t + 22);
        cycle(4);
        total++;
        if (press_count !== 8'd1 || held !== 1'b1) begin
            bad++;
            $display("FAIL rst_long_repress count=%0d held=%b required 1/1", press_count, held);
        end
        push(1, t + 26);
        keyin = 1'b1;
        cycle(6);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rst_long_missing got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_hold();
        test_release_at_terminal();
        test_back_to_back();
        test_wrap();
        test_reset_in_long();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
